// File: rtl/dmem_unit.sv
// MEM-stage word-addressed data memory on a shared tristate data bus.
// Self-clears via an INIT sweep after reset; keeps sticky error flags and saturating counters.
module dmem_unit #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             lw,
  input  logic             sw,
  inout  tri   [31:0]      databus,
  output logic             ready,
  output logic             err_align,
  output logic             err_range,
  output logic             err_conflict,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] init_ptr_q, init_ptr_d;
  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  aligned, inrange, valid, run;
  logic                  do_load, do_store, drive_en;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  assign idx      = addr[DEPTH_LOG2+1:2];
  assign aligned  = (addr[1:0] == 2'b00);
  assign inrange  = (addr[31:DEPTH_LOG2+2] == '0);
  assign valid    = aligned & inrange;
  assign run      = (state_q == StRun);
  assign do_load  = run & lw & ~sw & valid;
  assign do_store = run & sw & ~lw & valid;
  assign drive_en = run & lw & ~sw;

  // Invalid loads drive zero so the processor never latches a floating bus.
  assign databus = drive_en ? (valid ? mem[idx] : 32'h0000_0000) : 'z;
  assign ready   = run;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = idx;
    mem_wdata  = databus;
    unique case (state_q)
      StInit: begin
        mem_we     = 1'b1;
        mem_waddr  = init_ptr_q;
        mem_wdata  = 32'h0000_0000;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == DEPTH_LOG2'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we = do_store;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StInit;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_align    <= 1'b0;
      err_range    <= 1'b0;
      err_conflict <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else if (run && (lw || sw)) begin
      if (!aligned) err_align <= 1'b1;
      if (!inrange) err_range <= 1'b1;
      if (lw && sw) err_conflict <= 1'b1;
      if (do_load && (rd_count != '1)) rd_count <= rd_count + 1'b1;
      if (do_store && (wr_count != '1)) wr_count <= wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_dmem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        lw, sw;
  tri   [31:0] databus;
  logic        proc_en;
  logic [31:0] proc_data;
  logic        ready, err_align, err_range, err_conflict;
  logic [15:0] rd_count, wr_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_mem [256];
  int          m_rd, m_wr;
  bit          m_al, m_rg, m_cf;

  assign databus = proc_en ? proc_data : 'z;

  always #5 clk = ~clk;

  dmem_unit #(.DEPTH_LOG2(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .addr(addr), .lw(lw), .sw(sw), .databus(databus),
    .ready(ready), .err_align(err_align), .err_range(err_range),
    .err_conflict(err_conflict), .rd_count(rd_count), .wr_count(wr_count)
  );

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a);
    return addr_ok(a) ? m_mem[a / 4] : 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    m_rd = 0; m_wr = 0; m_al = 0; m_rg = 0; m_cf = 0;
  endtask

  task automatic model_apply(input logic l, input logic s, input logic [31:0] a,
                             input logic [31:0] d);
    if (!(l || s)) return;
    if (a % 4 != 0) m_al = 1;
    if (a >= 32'd1024) m_rg = 1;
    if (l && s) m_cf = 1;
    else if (addr_ok(a)) begin
      if (l) m_rd = (m_rd < 65535) ? m_rd + 1 : 65535;
      else begin
        m_mem[a / 4] = d;
        m_wr = (m_wr < 65535) ? m_wr + 1 : 65535;
      end
    end
  endtask

  // One bus cycle starting just after a posedge; returns the bus value seen mid-cycle.
  task automatic step(input logic l, input logic s, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] seen);
    lw = l; sw = s; addr = a; proc_data = d; proc_en = s;
    #4;
    seen = databus;
    @(posedge clk);
    #1;
    model_apply(l, s, a, d);
    lw = 1'b0; sw = 1'b0; proc_en = 1'b0;
  endtask

  task automatic wait_init();
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (ready !== ((i == 256) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL ready_sweep posedge %0d: got %b want %b", i, ready, i == 256);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] seen;
    reset = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b0 || rd_count !== 16'h0 || wr_count !== 16'h0 ||
        {err_align, err_range, err_conflict} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b rd=%h wr=%h flags=%b%b%b want all zero",
               ready, rd_count, wr_count, err_align, err_range, err_conflict);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    wait_init();
    step(1'b1, 1'b0, 32'h0, 32'h0, seen);
    vectors++;
    if (seen !== 32'h0) begin
      miscompares++;
      $display("FAIL first_load: got %h want 00000000", seen);
    end
    vectors++;
    if (rd_count !== 16'd1) begin
      miscompares++;
      $display("FAIL first_rd_count: got %0d want 1", rd_count);
    end
  endtask

  task automatic test_raw();
    logic [31:0] seen;
    step(1'b0, 1'b1, 32'h10, 32'h1234_5678, seen);
    step(1'b1, 1'b0, 32'h10, 32'h0, seen);
    vectors++;
    if (seen !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL raw_data: got %h want 12345678", seen);
    end
    vectors++;
    if (wr_count !== 16'(m_wr) || rd_count !== 16'(m_rd)) begin
      miscompares++;
      $display("FAIL raw_counts: rd=%0d wr=%0d want rd=%0d wr=%0d",
               rd_count, wr_count, m_rd, m_wr);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] seen;
    logic [15:0] rd_before;
    rd_before = 16'(m_rd);
    step(1'b1, 1'b0, 32'h2, 32'h0, seen);
    vectors++;
    if (seen !== 32'h0) begin
      miscompares++;
      $display("FAIL misaligned_bus: got %h want 00000000", seen);
    end
    vectors++;
    if (err_align !== 1'b1 || rd_count !== rd_before) begin
      miscompares++;
      $display("FAIL misaligned_flag: err_align=%b rd=%0d want 1 and %0d",
               err_align, rd_count, rd_before);
    end
    step(1'b0, 1'b1, 32'h14, 32'h0BAD_CAFE, seen);
    step(1'b1, 1'b0, 32'h14, 32'h0, seen);
    vectors++;
    if (err_align !== 1'b1 || seen !== 32'h0BAD_CAFE) begin
      miscompares++;
      $display("FAIL align_sticky: err_align=%b bus=%h want 1 and 0badcafe", err_align, seen);
    end
  endtask

  task automatic test_range();
    logic [31:0] seen;
    step(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, seen);
    vectors++;
    if (err_range !== 1'b1 || wr_count !== 16'(m_wr)) begin
      miscompares++;
      $display("FAIL range_flag: err_range=%b wr=%0d want 1 and %0d", err_range, wr_count, m_wr);
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, seen);
    vectors++;
    if (seen !== 32'h0) begin
      miscompares++;
      $display("FAIL range_no_write: mem[0]=%h want 00000000", seen);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] seen;
    step(1'b0, 1'b1, 32'h20, 32'h1111_1111, seen);
    step(1'b1, 1'b1, 32'h20, 32'hAAAA_5555, seen);
    vectors++;
    if (seen !== 32'hAAAA_5555) begin
      miscompares++;
      $display("FAIL conflict_bus: got %h want aaaa5555 (processor only)", seen);
    end
    vectors++;
    if (err_conflict !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_flag: got %b want 1", err_conflict);
    end
    step(1'b1, 1'b0, 32'h20, 32'h0, seen);
    vectors++;
    if (seen !== 32'h1111_1111 || wr_count !== 16'(m_wr) || rd_count !== 16'(m_rd)) begin
      miscompares++;
      $display("FAIL conflict_no_write: mem=%h rd=%0d wr=%0d want 11111111 %0d %0d",
               seen, rd_count, wr_count, m_rd, m_wr);
    end
  endtask

  task automatic test_random();
    logic [31:0] seen, a, d, want;
    logic        l, s;
    int          kind;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      l = (kind <= 3) || (kind == 8);
      s = (kind >= 4 && kind <= 8);
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(0, 1023);
        1:       a = $urandom;
        default: a = $urandom_range(0, 255) * 4;
      endcase
      d = $urandom;
      want = exp_load(a);
      step(l, s, a, d, seen);
      if (l && !s) begin
        vectors++;
        if (seen !== want) begin
          miscompares++;
          $display("FAIL rand_load[%0d] addr %h: got %h want %h", n, a, seen, want);
        end
      end
      vectors++;
      if (rd_count !== 16'(m_rd) || wr_count !== 16'(m_wr) ||
          {err_align, err_range, err_conflict} !== {m_al, m_rg, m_cf}) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: rd=%0d wr=%0d flags=%b%b%b want %0d %0d %b%b%b", n,
                 rd_count, wr_count, err_align, err_range, err_conflict, m_rd, m_wr,
                 m_al, m_rg, m_cf);
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] seen;
    while (m_wr < 65535) step(1'b0, 1'b1, 32'h80, 32'(m_wr), seen);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (wr_count !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL wr_saturate[%0d]: got %h want ffff", i, wr_count);
      end
      step(1'b0, 1'b1, 32'h84, 32'h5A5A_0000 + 32'(i), seen);
    end
    vectors++;
    if (wr_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wr_saturate_hold: got %h want ffff", wr_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] seen;
    step(1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, seen);
    lw = 1'b1; addr = 32'h44;
    #2;
    vectors++;
    if (databus !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL mid_load_drive: got %h want cafef00d", databus);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (databus === 32'hCAFE_F00D || ready !== 1'b0 || rd_count !== 16'h0 ||
        wr_count !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_reset_release: bus=%h ready=%b rd=%h wr=%h want released 0 0 0",
               databus, ready, rd_count, wr_count);
    end
    lw = 1'b0; sw = 1'b1; addr = 32'h48; proc_data = 32'h5555_AAAA; proc_en = 1'b1;
    @(posedge clk);
    #3;
    sw = 1'b0; proc_en = 1'b0;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    #1;
    wait_init();
    step(1'b1, 1'b0, 32'h44, 32'h0, seen);
    vectors++;
    if (seen !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_clear: got %h want 00000000", seen);
    end
    step(1'b1, 1'b0, 32'h48, 32'h0, seen);
    vectors++;
    if (seen !== 32'h0 || rd_count !== 16'd2) begin
      miscompares++;
      $display("FAIL post_reset_lost_store: bus=%h rd=%0d want 00000000 2", seen, rd_count);
    end
  endtask

  initial begin
    lw = 1'b0; sw = 1'b0; addr = 32'h0; proc_en = 1'b0; proc_data = 32'h0;
    reset = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_raw();
    test_misaligned();
    test_range();
    test_conflict();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
